// File: rtl/block_color_pipeline_pkg.sv
// Shared types for the pixel colour pipeline: palette, RGB struct, glyph geometry.
// Pure declarations; no latency or flow control of its own.
package block_color_pipeline_pkg;

  typedef enum logic [2:0] {
    EMPTY, CYAN, BLUE, ORANGE, YELLOW, GREEN, RED, MAGENTA
  } block_color;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Per-pixel context carried alongside the font ROM read.
  typedef struct packed {
    logic       vld;
    logic       play;
    block_color color;
    logic       flash;
    logic       blank;
    logic [2:0] bit_idx;
    logic [6:0] xcol;
  } sideband_t;

  localparam int         FONT_GLYPH_H = 16;
  localparam logic [7:0] BG_R         = 8'h1F;
  localparam logic [7:0] BG_B_BASE    = 8'h7F;
  localparam rgb_t       RGB_WHITE    = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

  function automatic rgb_t block_to_rgb(input block_color c);
    case (c)
      CYAN:    return '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      BLUE:    return '{r: 8'h00, g: 8'h00, b: 8'hFF};
      ORANGE:  return '{r: 8'hFF, g: 8'hA5, b: 8'h00};
      YELLOW:  return '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      GREEN:   return '{r: 8'h00, g: 8'h80, b: 8'h00};
      RED:     return '{r: 8'hFF, g: 8'h00, b: 8'h00};
      MAGENTA: return '{r: 8'hFF, g: 8'h00, b: 8'hFF};
      default: return '{r: 8'h00, g: 8'h00, b: 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/block_color_pipeline_score_digit_shadow.sv
// Frame-latched copy of the BCD score plus its leading-zero blanking mask.
// Loads on load_i; one-cycle update, never stalls.
module score_digit_shadow
  import block_color_pipeline_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    lz_suppress_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   lz_mask_o
);

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   mask_d, mask_q;
  logic                    zero_run;

  // Mask bit d is indexed from the MS digit; the LS digit is never masked.
  always_comb begin
    mask_d   = '0;
    zero_run = lz_suppress_i;
    for (int d = 0; d < NUM_DIGITS - 1; d++) begin
      zero_run  = zero_run && (digits_i[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
      mask_d[d] = zero_run;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q <= '0;
      mask_q   <= '0;
    end else if (load_i) begin
      digits_q <= digits_i;
      mask_q   <= mask_d;
    end
  end

  assign digits_o  = digits_q;
  assign lz_mask_o = mask_q;

endmodule

// File: rtl/block_color_pipeline.sv
// Maps each VGA pixel to RGB (flash, playfield palette, score glyph or gradient).
// Latency 1+ROM_LATENCY cycles, one pixel per cycle, no backpressure.
module block_color_pipeline
  import block_color_pipeline_pkg::*;
#(
  parameter int          NUM_DIGITS      = 6,
  parameter logic [9:0]  SCORE_X_MIN     = 10'd296,
  parameter logic [9:0]  SCORE_Y_MIN     = 10'd10,
  parameter logic [10:0] FONT_DIGIT_BASE = 11'd768,
  parameter int          ROM_LATENCY     = 1,
  parameter int          NUM_ROWS        = 20,
  parameter int          FLASH_FRAMES    = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    play_area,
  input  logic                    score_area,
  input  block_color              block_type,
  input  logic [4:0]              play_row,
  input  logic [4*NUM_DIGITS-1:0] score_digits_in,
  input  logic                    flash_en,
  input  logic [NUM_ROWS-1:0]     flash_rows,
  input  logic                    lz_suppress,
  output logic [10:0]             rom_addr,
  input  logic [7:0]              rom_data,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    out_valid,
  output logic                    flash_phase
);

  localparam int         CW     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   lz_mask;

  score_digit_shadow #(.NUM_DIGITS(NUM_DIGITS)) u_shadow (
    .clk_i         (Clk),
    .rst_ni        (Reset_n),
    .load_i        (frame_start),
    .digits_i      (score_digits_in),
    .lz_suppress_i (lz_suppress),
    .digits_o      (shadow_digits),
    .lz_mask_o     (lz_mask)
  );

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Dropping flash_en wins over any frame_start in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!flash_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      state_d = S_RUN;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (frame_start) begin
      if (cnt_q == CW'(FLASH_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  logic [6:0]  dig_idx;
  logic [3:0]  nib;
  logic        lz_blank, blank;
  logic [31:0] rows_pad;
  logic [10:0] addr_d, rom_addr_q;
  sideband_t   s0_d, s0_q;

  always_comb begin
    dig_idx  = 7'((DrawX - SCORE_X_MIN) >> 3);
    nib      = '0;
    lz_blank = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (dig_idx == 7'(d)) begin
        nib      = shadow_digits[4*(NUM_DIGITS-1-d) +: 4];
        lz_blank = lz_mask[d];
      end
    end
    blank = !score_area || (dig_idx >= 7'(NUM_DIGITS)) || (nib > 4'd9) || lz_blank;
    // Zero padding makes rows beyond NUM_ROWS never flash.
    rows_pad      = 32'(flash_rows);
    s0_d          = '0;
    s0_d.vld      = pix_valid;
    s0_d.play     = play_area;
    s0_d.color    = block_type;
    s0_d.flash    = play_area && flash_en && phase_q && rows_pad[play_row];
    s0_d.blank    = blank;
    s0_d.bit_idx  = ~DrawX[2:0];
    s0_d.xcol     = DrawX[9:3];
    addr_d = (pix_valid && !blank)
           ? FONT_DIGIT_BASE + (11'(nib) << $clog2(FONT_GLYPH_H))
             + 11'((DrawY - SCORE_Y_MIN) & 10'h00F)
           : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s0_q       <= '0;
      rom_addr_q <= '0;
    end else begin
      s0_q       <= s0_d;
      rom_addr_q <= addr_d;
    end
  end

  assign rom_addr = rom_addr_q;

  sideband_t dly_q [ROM_LATENCY];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ROM_LATENCY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= s0_q;
      for (int i = 1; i < ROM_LATENCY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  sideband_t sb;
  rgb_t      pix_rgb, hold_q, out_rgb;

  assign sb = dly_q[ROM_LATENCY-1];

  always_comb begin
    pix_rgb = '{r: BG_R, g: 8'h00, b: BG_B_BASE - {1'b0, sb.xcol}};
    if (sb.flash)                             pix_rgb = RGB_WHITE;
    else if (sb.play)                         pix_rgb = block_to_rgb(sb.color);
    else if (!sb.blank && rom_data[sb.bit_idx]) pix_rgb = RGB_WHITE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    hold_q <= '0;
    else if (sb.vld) hold_q <= pix_rgb;
  end

  assign out_rgb     = sb.vld ? pix_rgb : hold_q;
  assign VGA_R       = out_rgb.r;
  assign VGA_G       = out_rgb.g;
  assign VGA_B       = out_rgb.b;
  assign out_valid   = sb.vld;
  assign flash_phase = phase_q;

endmodule

// File: tb/tb_block_color_pipeline.sv
// Directed plus random stimulus against a frame-level colour model, for ROM latency 1 and 2.
module tb_block_color_pipeline;
  import block_color_pipeline_pkg::*;

  localparam int ND = 6;
  localparam int FF = 2;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             frame_start, pix_valid, play_area, score_area, flash_en, lz_suppress;
  logic [9:0]       DrawX, DrawY;
  block_color       block_type;
  logic [4:0]       play_row;
  logic [4*ND-1:0]  score_digits_in;
  logic [19:0]      flash_rows;
  logic [10:0]      rom_addr1, rom_addr2;
  logic [7:0]       rom_data1, rom_data2, rom_mid2;
  logic [7:0]       r1, g1, b1, r2, g2, b2;
  logic             ov1, ov2, fp1, fp2;

  always #5 Clk = ~Clk;

  block_color_pipeline #(.ROM_LATENCY(1), .FLASH_FRAMES(FF)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .play_area(play_area), .score_area(score_area),
    .block_type(block_type), .play_row(play_row), .score_digits_in(score_digits_in),
    .flash_en(flash_en), .flash_rows(flash_rows), .lz_suppress(lz_suppress),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .out_valid(ov1), .flash_phase(fp1));

  block_color_pipeline #(.ROM_LATENCY(2), .FLASH_FRAMES(FF)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .play_area(play_area), .score_area(score_area),
    .block_type(block_type), .play_row(play_row), .score_digits_in(score_digits_in),
    .flash_en(flash_en), .flash_rows(flash_rows), .lz_suppress(lz_suppress),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
    .out_valid(ov2), .flash_phase(fp2));

  // Arbitrary but fixed font contents so glyph bits vary with address.
  function automatic logic [7:0] font_byte(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction

  always @(posedge Clk) begin
    rom_data1 <= font_byte(rom_addr1);
    rom_mid2  <= font_byte(rom_addr2);
    rom_data2 <= rom_mid2;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [3:0]  m_dig [ND];
  bit          m_lz;
  int          m_frames;
  bit          m_run;
  int          cyc;
  logic [23:0] e1 [int];
  logic [23:0] e2 [int];
  logic [10:0] ea [int];
  logic [23:0] last1, last2;

  function automatic logic [23:0] palette(input int c);
    logic [23:0] tbl [8];
    tbl = '{24'h000000, 24'h00FFFF, 24'h0000FF, 24'hFFA500,
            24'hFFFF00, 24'h008000, 24'hFF0000, 24'hFF00FF};
    return tbl[c];
  endfunction

  function automatic bit m_digit_blank(input int d);
    if (m_dig[d] > 4'd9) return 1'b1;
    if (!m_lz || d == ND - 1) return 1'b0;
    for (int j = 0; j <= d; j++) if (m_dig[j] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_phase();
    return m_run && (((m_frames / FF) % 2) == 1);
  endfunction

  task automatic model_pixel();
    int x, y, d, addr;
    bit req;
    logic [7:0]  fb;
    logic [23:0] rgb, bg;
    x = int'(DrawX);
    y = int'(DrawY);
    req = 1'b0;
    addr = 0;
    if (score_area && x >= 296 && (x - 296) / 8 < ND) begin
      d = (x - 296) / 8;
      if (!m_digit_blank(d)) begin
        req  = 1'b1;
        addr = 768 + 16 * int'(m_dig[d]) + ((y - 10) & 15);
      end
    end
    bg = {8'h1F, 8'h00, 8'(127 - x / 8)};
    if (play_area && flash_en && m_phase() && play_row < 20 && flash_rows[play_row])
      rgb = 24'hFFFFFF;
    else if (play_area)
      rgb = palette(int'(block_type));
    else if (req) begin
      fb  = font_byte(11'(addr));
      rgb = fb[7 - (x % 8)] ? 24'hFFFFFF : bg;
    end else
      rgb = bg;
    e1[cyc + 2] = rgb;
    e2[cyc + 3] = rgb;
    if (req) ea[cyc + 1] = 11'(addr);
  endtask

  task automatic check_out();
    logic [23:0] exp;
    logic [10:0] ax;
    chk("out_valid_l1", 32'(ov1), 32'(e1.exists(cyc)));
    exp = last1;
    if (e1.exists(cyc)) begin exp = e1[cyc]; e1.delete(cyc); end
    chk("rgb_l1", 32'({r1, g1, b1}), 32'(exp));
    last1 = exp;
    chk("out_valid_l2", 32'(ov2), 32'(e2.exists(cyc)));
    exp = last2;
    if (e2.exists(cyc)) begin exp = e2[cyc]; e2.delete(cyc); end
    chk("rgb_l2", 32'({r2, g2, b2}), 32'(exp));
    last2 = exp;
    ax = '0;
    if (ea.exists(cyc)) begin ax = ea[cyc]; ea.delete(cyc); end
    chk("rom_addr_l1", 32'(rom_addr1), 32'(ax));
    chk("rom_addr_l2", 32'(rom_addr2), 32'(ax));
    chk("flash_phase_l1", 32'(fp1), 32'(m_phase()));
    chk("flash_phase_l2", 32'(fp2), 32'(m_phase()));
  endtask

  task automatic step();
    if (pix_valid) model_pixel();
    if (!flash_en) begin m_run = 1'b0; m_frames = 0; end
    else if (!m_run) begin m_run = 1'b1; m_frames = 0; end
    else if (frame_start) m_frames++;
    if (frame_start) begin
      for (int d = 0; d < ND; d++) m_dig[d] = score_digits_in[4*(ND-1-d) +: 4];
      m_lz = lz_suppress;
    end
    @(posedge Clk);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; frame_start = 1'b0; flash_en = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'({ov1, ov2}), 32'd0);
    chk("rst_rgb_l1", 32'({r1, g1, b1}), 32'd0);
    chk("rst_rgb_l2", 32'({r2, g2, b2}), 32'd0);
    chk("rst_rom_addr", 32'({rom_addr1, rom_addr2}), 32'd0);
    chk("rst_phase", 32'({fp1, fp2}), 32'd0);
    e1.delete(); e2.delete(); ea.delete();
    last1 = '0; last2 = '0;
    m_run = 1'b0; m_frames = 0; m_lz = 1'b0;
    for (int d = 0; d < ND; d++) m_dig[d] = 4'd0;
    repeat (2) @(posedge Clk);
    #1;
    cyc += 2;
    Reset_n = 1'b1;
  endtask

  task automatic pix(input int x, input int y, input bit pa, input bit sa,
                     input int col, input int row);
    pix_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
    play_area = pa; score_area = sa;
    block_type = block_color'(3'(col)); play_row = 5'(row);
  endtask

  task automatic frame(input logic [23:0] s, input bit lz);
    pix_valid = 1'b0; frame_start = 1'b1; score_digits_in = s; lz_suppress = lz;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    play_area = 1'b0; score_area = 1'b0; block_type = EMPTY; play_row = '0;
    score_digits_in = '0; flash_en = 1'b0; flash_rows = '0; lz_suppress = 1'b0;
    cyc = 0;
    do_reset();

    // Single orange playfield pixel.
    pix(100, 100, 1, 0, 3, 2); step();
    pix_valid = 1'b0; step();
    chk("orange_l1", 32'({ov1, r1, g1, b1}), 32'h1FFA500);
    step();
    chk("orange_l2", 32'({ov2, r2, g2, b2}), 32'h1FFA500);
    repeat (3) step();

    // Score 000120 with leading-zero suppression.
    frame(24'h000120, 1'b1);
    pix(320, 12, 0, 1, 0, 0); step();
    chk("addr_786", 32'(rom_addr1), 32'd786);
    pix(296, 12, 0, 1, 0, 0); step();
    chk("addr_lz_blank", 32'(rom_addr1), 32'd0);
    pix_valid = 1'b0; repeat (3) step();

    // All-zero score keeps only the LS digit.
    frame(24'h000000, 1'b1);
    for (int d = 0; d < ND; d++) begin
      pix(296 + 8 * d + 1, 14, 0, 1, 0, 0); step();
      chk("addr_zero_score", 32'(rom_addr1), (d == ND - 1) ? 32'd772 : 32'd0);
    end
    frame(24'hBBBBBB, 1'b0);
    for (int d = 0; d < ND; d++) begin
      pix(296 + 8 * d + 5, 18, 0, 1, 0, 0); step();
      chk("addr_nibble_b", 32'(rom_addr1), 32'd0);
    end
    frame(24'h0B1034, 1'b1);
    for (int d = 0; d < ND; d++) begin pix(296 + 8 * d + 2, 11, 0, 1, 0, 0); step(); end

    // Live score changes without frame_start are not rendered.
    frame(24'h123456, 1'b0);
    score_digits_in = 24'h987654;
    for (int d = 0; d < ND; d++) begin
      pix(296 + 8 * d, 20, 0, 1, 0, 0); step();
      chk("addr_shadow", 32'(rom_addr1), 32'(768 + 16 * (d + 1) + 10));
    end
    frame_start = 1'b1; pix(296, 20, 0, 1, 0, 0); step(); frame_start = 1'b0;
    chk("addr_old_at_load", 32'(rom_addr1), 32'(768 + 16 + 10));
    pix(296, 20, 0, 1, 0, 0); step();
    chk("addr_new_after_load", 32'(rom_addr1), 32'(768 + 16 * 9 + 10));

    // Flash animation on row 19.
    flash_rows = 20'h80000; flash_en = 1'b1;
    pix_valid = 1'b0; step();
    for (int f = 0; f < 9; f++) begin
      frame_start = 1'b1; pix(200, 300, 1, 0, 5, 19); step(); frame_start = 1'b0;
      chk("flash_toggle", 32'(fp1), 32'(((f + 1) / 2) % 2));
      pix(200, 301, 1, 0, 5, 5); step();
      pix(208, 302, 1, 0, 5, 19); step();
      pix(216, 303, 1, 0, 2, 25); step();
    end
    flash_en = 1'b0; frame_start = 1'b1; pix(200, 300, 1, 0, 5, 19); step();
    frame_start = 1'b0;
    chk("flash_drop", 32'(fp1), 32'd0);
    pix_valid = 1'b0; repeat (3) step();

    // Right-edge gradient pixel.
    pix(640, 200, 0, 0, 0, 0); step();
    pix_valid = 1'b0; step();
    chk("bg640_l1", 32'({r1, g1, b1}), 32'h1F002F);
    step();
    chk("bg640_l2", 32'({r2, g2, b2}), 32'h1F002F);

    // Random traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      pix_valid = ($urandom % 4) != 0;
      if ($urandom % 3 == 0) begin
        DrawX = 10'($urandom_range(280, 360));
        DrawY = 10'($urandom_range(0, 30));
      end else begin
        DrawX = 10'($urandom % 800);
        DrawY = 10'($urandom % 525);
      end
      play_area   = ($urandom % 3) == 0;
      score_area  = $urandom % 2;
      block_type  = block_color'(3'($urandom % 8));
      play_row    = 5'($urandom % 32);
      frame_start = ($urandom % 40) == 0;
      lz_suppress = $urandom % 2;
      for (int d = 0; d < ND; d++)
        score_digits_in[4*d +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
      if ($urandom % 150 == 0) flash_en = !flash_en;
      if ($urandom % 50 == 0) flash_rows = 20'($urandom);
      step();
    end
    pix_valid = 1'b0; frame_start = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
